ifu_pc: RTL and testbench

IFU_PC -- requirements
Module: ifu_pc

---
 rtl/ifu_pc.sv | 96 +++++++++
 tb/tb_ifu_pc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifu_pc.sv
// ifu_pc: fetch-stage program counter with next-PC selection and a sticky fetch fault (RUN/HALT).
// Optional macro IFU_BOUNDS_CHECK_EN adds an instruction-memory range check on every target.
module ifu_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [9:0]  im_addr,
    output logic        fault,
    output logic [31:0] bad_addr
);

`ifdef IFU_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    // 33-bit end address so a window touching 2^32 does not wrap to zero
    localparam logic [32:0] ImEnd = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic        [31:0] pc_q, pc_d;
    logic        [31:0] bad_addr_q, bad_addr_d;
    logic signed [31:0] br_off;
    logic        [31:0] target;
    logic               misaligned;
    logic               out_of_range;
    logic               bad_target;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc       = pc_q;
    assign im_addr  = pc_q[11:2];
    assign fault    = (state_q == HALT);
    assign bad_addr = bad_addr_q;

    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        target = pc_plus4;
        case (npc_sel)
            2'b00: target = pc_plus4;
            2'b01: target = br_taken ? (pc_plus4 + $unsigned(br_off)) : pc_plus4;
            2'b10: target = {pc_plus4[31:28], instr_index, 2'b00};
            2'b11: target = rs_data;
        endcase
    end

    always_comb begin
        misaligned   = (target[1:0] != 2'b00);
        out_of_range = ({1'b0, target} < {1'b0, IM_BASE}) || ({1'b0, target} >= ImEnd);
        bad_target   = misaligned || (BoundsEn && out_of_range);
    end

    // A bad target freezes the PC and latches the offending address until reset
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        if (state_q == RUN && !stall) begin
            if (bad_target) begin
                state_d    = HALT;
                bad_addr_d = target;
            end else begin
                pc_d = target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            bad_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
        end
    end

endmodule

// File: tb/tb_ifu_pc.sv
// tb_ifu_pc: directed vectors for ifu_pc; expected state is queued by the driver and checked by a monitor.
// Expectations for out-of-range targets follow IFU_BOUNDS_CHECK_EN when it is defined.
module tb_ifu_pc;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [9:0]  im_addr;
    logic        fault;
    logic [31:0] bad_addr;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fault;
        logic [31:0] bad;
    } exp_t;

    exp_t sb[$];
    event mon_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    ifu_pc dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .im_addr     (im_addr),
        .fault       (fault),
        .bad_addr    (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input logic [31:0] epc, input logic ef,
                            input logic [31:0] ebad);
        exp_t e;
        e.name  = nm;
        e.pc    = epc;
        e.fault = ef;
        e.bad   = ebad;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs at the falling edge; the expectation applies after the next rising edge
    task automatic step(input string nm, input logic s, input logic [1:0] sel, input logic bt,
                        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                        input logic [31:0] epc, input logic ef, input logic [31:0] ebad);
        @(negedge clk);
        stall       = s;
        npc_sel     = sel;
        br_taken    = bt;
        imm16       = imm;
        instr_index = idx;
        rs_data     = rs;
        push_exp(nm, epc, ef, ebad);
    endtask

    // Reset pulse in the low phase; state must change before any clock edge
    task automatic pulse_reset(input string nm);
        @(negedge clk);
        stall   = 1'b1;
        npc_sel = 2'b00;
        rst     = 1'b1;
        #2;
        rst     = 1'b0;
        push_exp(nm, 32'h0000_3000, 1'b0, 32'h0);
        ->mon_ev;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] e_p4;
        logic [9:0]  e_im;
        forever begin
            @(posedge clk or mon_ev);
            #1;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                e_p4 = e.pc + 32'd4;
                e_im = e.pc[11:2];
                n_tests++;
                if (pc !== e.pc || pc_plus4 !== e_p4 || im_addr !== e_im ||
                    fault !== e.fault || bad_addr !== e.bad) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h pc_plus4=%h im_addr=%h fault=%b bad_addr=%h, want pc=%h pc_plus4=%h im_addr=%h fault=%b bad_addr=%h",
                             e.name, pc, pc_plus4, im_addr, fault, bad_addr,
                             e.pc, e_p4, e_im, e.fault, e.bad);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst         = 1'b1;
        stall       = 1'b1;
        npc_sel     = 2'b00;
        br_taken    = 1'b0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        rs_data     = 32'h0;
        #12;
        rst = 1'b0;

        step("seq_first", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 1'b0, 32'h0);
        pulse_reset("reset_mid_cycle");
        step("seq_1",   1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 1'b0, 32'h0);
        step("seq_2",   1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3008, 1'b0, 32'h0);
        step("seq_3",   1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_300C, 1'b0, 32'h0);
        step("stall_1", 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_300C, 1'b0, 32'h0);
        step("stall_2", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3800, 32'h0000_300C, 1'b0, 32'h0);

        step("jr_3010",   1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 32'h0000_3010, 1'b0, 32'h0);
        step("br_taken_back", 1'b0, 2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3004, 1'b0, 32'h0);
        step("jr_3010b",  1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 32'h0000_3010, 1'b0, 32'h0);
        step("br_not_taken", 1'b0, 2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3014, 1'b0, 32'h0);
        step("jr_3000",   1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3000, 32'h0000_3000, 1'b0, 32'h0);
        step("jump",      1'b0, 2'b10, 1'b0, 16'h0, 26'h0000C08, 32'h0, 32'h0000_3020, 1'b0, 32'h0);
        step("jr_3040",   1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3040, 32'h0000_3040, 1'b0, 32'h0);
        step("jr_3ffc",   1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3FFC, 32'h0000_3FFC, 1'b0, 32'h0);
`ifdef IFU_BOUNDS_CHECK_EN
        step("seq_past_end", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3FFC, 1'b1, 32'h0000_4000);
`else
        step("seq_past_end", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_4000, 1'b0, 32'h0);
`endif
        pulse_reset("reset_2");

        step("bad_jr_stalled", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3042, 32'h0000_3000, 1'b0, 32'h0);
        step("bad_jr",         1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3042, 32'h0000_3000, 1'b1, 32'h0000_3042);
        step("halt_seq",       1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3000, 1'b1, 32'h0000_3042);
        step("halt_bad_again", 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3045, 32'h0000_3000, 1'b1, 32'h0000_3042);
        step("halt_stall",     1'b1, 2'b01, 1'b1, 16'h0004, 26'h0, 32'h0, 32'h0000_3000, 1'b1, 32'h0000_3042);
        pulse_reset("reset_in_halt");
        step("seq_after_halt", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 1'b0, 32'h0);
        step("br_taken_fwd",   1'b0, 2'b01, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h0000_3014, 1'b0, 32'h0);

`ifdef IFU_BOUNDS_CHECK_EN
        step("jr_top",  1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0000_3014, 1'b1, 32'hFFFF_FFFC);
        step("wrap_seq", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_3014, 1'b1, 32'hFFFF_FFFC);
`else
        step("jr_top",  1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("wrap_seq", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 1'b0, 32'h0);
`endif
        pulse_reset("reset_final");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected results never checked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
